modulo_contador_ud: RTL and testbench

MODULO_CONTADOR_UD -- requirements
Module: modulo_contador_ud

---
 rtl/contador_pkg.sv | 7 +
 rtl/modulo_proximo_estado.sv | 37 +++
 rtl/modulo_contador_ud.sv | 47 ++++
 tb/tb_modulo_contador_ud.sv | 137 +++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// contador_pkg: direction constants and parameter defaults shared by the modulo counter
package contador_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int WIDTH_DEF = 4;
  localparam int MODULO_DEF = 10;
endpackage

// File: rtl/modulo_proximo_estado.sv
// modulo_proximo_estado: combinational next count, wrap/terminal-count, illegal-load and toggle mask
module modulo_proximo_estado
  import contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MODULO = MODULO_DEF
) (
  input  logic             clr,
  input  logic             enable,
  input  logic             ci,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_d,
  output logic [WIDTH-1:0] t_out,
  output logic             tc_d,
  output logic             err_d
);
  // one extra bit so MODULO == 2**WIDTH is representable in the range compares
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);
  logic d_ok, q_ok, step, wrap, is_up;
  logic [WIDTH-1:0] cnt;
  always_comb begin
    is_up = up == DIR_UP;
    d_ok = {1'b0, d} < MOD_W;
    q_ok = {1'b0, q} < MOD_W;
    step = enable & ci & ~load;
    wrap = q_ok & (is_up ? q == MAX_V : q == '0);
    cnt = !q_ok ? '0 : wrap ? (is_up ? '0 : MAX_V) : is_up ? q + 1'b1 : q - 1'b1;
    q_d = clr ? '0 : (enable & load) ? (d_ok ? d : '0) : step ? cnt : q;
    tc_d = ~clr & step & wrap;
    err_d = ~clr & enable & load & ~d_ok;
    t_out = clr ? '0 : q ^ q_d;
  end
endmodule

// File: rtl/modulo_contador_ud.sv
// modulo_contador_ud: falling-edge up/down modulo counter with load; CONTADOR_CASCATA_EN adds ci/co cascade
module modulo_contador_ud
  import contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MODULO = MODULO_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`ifdef CONTADOR_CASCATA_EN
  input  logic             ci,
  output logic             co,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_out,
  output logic             tc,
  output logic             err
);
  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("modulo_contador_ud: MODULO must be in 2..2**WIDTH");
  end
  logic [WIDTH-1:0] q_q, q_d;
  logic tc_q, tc_d, err_q, err_d, c_in;
`ifdef CONTADOR_CASCATA_EN
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);
  assign c_in = ci;
  assign co = ci & enable & ~load & ((up == DIR_UP) ? q_q == MAX_V : q_q == '0);
`else
  assign c_in = 1'b1;
`endif
  modulo_proximo_estado #(.WIDTH(WIDTH), .MODULO(MODULO)) u_prox (
    .clr(clr), .enable(enable), .ci(c_in), .up(up), .load(load), .d(d), .q(q_q),
    .q_d(q_d), .t_out(t_out), .tc_d(tc_d), .err_d(err_d)
  );
  always_ff @(negedge clk) begin
    q_q <= q_d;
    tc_q <= tc_d;
    err_q <= err_d;
  end
  assign q = q_q;
  assign tc = tc_q;
  assign err = err_q;
endmodule

// File: tb/tb_modulo_contador_ud.sv
// tb_modulo_contador_ud: directed vectors for the falling-edge modulo-10 up/down counter
module tb_modulo_contador_ud;
  logic clk = 1'b0;
  logic clr, enable, up, load;
  logic [3:0] d, q, t_out;
  logic tc, err;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
`ifdef CONTADOR_CASCATA_EN
  logic ci, co, co_t, tc_t, err_t;
  logic [3:0] q_t, t_out_t;
  modulo_contador_ud dut (.clk(clk), .clr(clr), .enable(enable), .up(up), .load(load), .d(d),
    .ci(ci), .co(co), .q(q), .t_out(t_out), .tc(tc), .err(err));
  modulo_contador_ud tens (.clk(clk), .clr(clr), .enable(enable), .up(up), .load(load), .d(d),
    .ci(co), .co(co_t), .q(q_t), .t_out(t_out_t), .tc(tc_t), .err(err_t));
`else
  modulo_contador_ud dut (.clk(clk), .clr(clr), .enable(enable), .up(up), .load(load), .d(d),
    .q(q), .t_out(t_out), .tc(tc), .err(err));
`endif
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic c, input logic e, input logic u, input logic l, input logic [3:0] v);
    clr = c; enable = e; up = u; load = l; d = v;
    #1;
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic expect_state(input string tag, input int eq, input int etc, input int eerr);
    check({tag, ".q"}, int'(q), eq);
    check({tag, ".tc"}, int'(tc), etc);
    check({tag, ".err"}, int'(err), eerr);
  endtask
  int exp_q, prev;
  initial begin
`ifdef CONTADOR_CASCATA_EN
    ci = 1'b1;
`endif
    drive(1, 1, 1, 1, 4'd3);
    check("clr_tout", int'(t_out), 0);
    tick;
    expect_state("reset", 0, 0, 0);
    drive(0, 1, 1, 0, 4'd0);
    exp_q = 0;
    for (int i = 0; i < 12; i++) begin
      prev = exp_q;
      exp_q = (prev == 9) ? 0 : prev + 1;
      check($sformatf("up_tout%0d", i), int'(t_out), prev ^ exp_q);
      tick;
      expect_state($sformatf("up%0d", i), exp_q, (exp_q == 0) ? 1 : 0, 0);
    end
    drive(1, 0, 0, 0, 4'd0);
    tick;
    drive(0, 1, 0, 0, 4'd0);
    check("dn_tout0", int'(t_out), 9);
    tick;
    expect_state("dn0", 9, 1, 0);
    check("dn_tout1", int'(t_out), 9 ^ 8);
    tick;
    expect_state("dn1", 8, 0, 0);
    tick;
    expect_state("dn2", 7, 0, 0);
    drive(0, 1, 0, 1, 4'd7);
    tick;
    expect_state("ld7", 7, 0, 0);
    drive(0, 1, 0, 1, 4'd12);
    check("ld12_tout", int'(t_out), 7);
    tick;
    expect_state("ld12", 0, 0, 1);
    drive(0, 0, 0, 0, 4'd12);
    tick;
    expect_state("ld12_after", 0, 0, 0);
    drive(0, 1, 1, 1, 4'd9);
    tick;
    expect_state("ld9", 9, 0, 0);
    drive(0, 1, 1, 1, 4'd10);
    tick;
    expect_state("ld10", 0, 0, 1);
    drive(0, 1, 1, 1, 4'd5);
    tick;
    drive(0, 0, 1, 1, 4'd3);
    check("hold_tout", int'(t_out), 0);
    tick;
    expect_state("hold", 5, 0, 0);
    drive(1, 1, 1, 1, 4'd3);
    check("clrld_tout", int'(t_out), 0);
    tick;
    expect_state("clr_ld", 0, 0, 0);
    drive(0, 1, 1, 1, 4'd9);
    tick;
    drive(0, 1, 1, 0, 4'd0);
    tick;
    expect_state("flip_up", 0, 1, 0);
    drive(0, 1, 0, 0, 4'd0);
    tick;
    expect_state("flip_dn", 9, 1, 0);
    drive(1, 1, 0, 0, 4'd0);
    tick;
    expect_state("mid_clr", 0, 0, 0);
    drive(0, 1, 1, 0, 4'd0);
    tick;
    expect_state("resume", 1, 0, 0);
`ifdef CONTADOR_CASCATA_EN
    begin
      int wraps = 0, ttc = 0;
      drive(1, 1, 1, 0, 4'd0);
      tick;
      drive(0, 1, 1, 0, 4'd0);
      for (int i = 0; i < 100; i++) begin
        tick;
        wraps += int'(tc);
        ttc += int'(tc_t);
        if (i == 98) check("tens_at9", int'(q_t), 9);
      end
      check("units_wraps", wraps, 10);
      check("tens_tc", ttc, 1);
      check("tens_q", int'(q_t), 0);
      tick;
      tick;
      ci = 1'b0;
      #1;
      check("co_off", int'(co), 0);
      for (int i = 0; i < 15; i++) tick;
      check("ci0_units", int'(q), 2);
      check("ci0_tens", int'(q_t), 0);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
